pc_fetch_stage: RTL

//  Program-counter register plus instruction-fetch sequencer; consumes the incremented PC from the
//  PC adder and drives instruction memory. Holds the current PC, selects the next PC
//  (sequential PC+4 or branch target), runs a req/ack handshake with instruction memory and presents
//  {PC, instruction} to decode/control with a valid flag. Sits between the PC adder and the control unit.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/pc_incrementer.sv | 19 +
 rtl/pc_fetch_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default constants for the instruction fetch stage
//
// Purpose : sequencer state encoding and default widths/reset PC/increment
//           used by pc_fetch_stage and pc_incrementer.
// Ports   : none (package).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int          DEFAULT_ADDR_W   = 64;
  localparam int          DEFAULT_INSTR_W  = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
  localparam int          DEFAULT_PC_INC   = 4;

endpackage

// File: rtl/pc_incrementer.sv
// rtl/pc_incrementer.sv - sequential next-PC adder (pc + PC_INC, wraps modulo 2^ADDR_W)
//
// Purpose : the single adder of the fetch stage; its result is both the next
//           sequential PC and the PCPlus4 value of the instruction being latched.
// Ports   : pc      in  ADDR_W  current program counter
//           pc_next out ADDR_W  pc + PC_INC, carry out discarded
module pc_incrementer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int PC_INC = DEFAULT_PC_INC
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  assign pc_next = pc + ADDR_W'(PC_INC);

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - program counter and instruction fetch sequencer
//
// Purpose : holds the PC, selects sequential or branch next PC, runs the
//           req/ack handshake with instruction memory and presents
//           {PCOut, InstrOut} to decode with InstrValid.
// Ports   : Clock, Reset (async, active high)
//           Branch, BranchTarget   redirect request and address
//           Stall                  decode not ready, hold presented instruction
//           imem_req, imem_addr    fetch request / address (stable until ack)
//           imem_ack, imem_rdata   fetch response
//           PCOut, PCPlus4, InstrOut, InstrValid  presented instruction
// Config  : FETCH_BUFFER_EN adds a one-entry skid buffer so fetching continues
//           while stalled; without it fetch halts in HOLD during Stall.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                PC_INC   = DEFAULT_PC_INC
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Branch,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic               Stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PCOut,
  output logic [ADDR_W-1:0]  PCPlus4,
  output logic [INSTR_W-1:0] InstrOut,
  output logic               InstrValid
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] addr_q;
  logic              squash;
  logic              ack_hit;
  logic              outstanding;

  pc_incrementer #(
    .ADDR_W (ADDR_W),
    .PC_INC (PC_INC)
  ) u_pc_incrementer (
    .pc      (pc),
    .pc_next (pc_inc)
  );

`ifdef FETCH_BUFFER_EN
  logic               buf_valid;
  logic [ADDR_W-1:0]  buf_pc;
  logic [ADDR_W-1:0]  buf_pc_plus;
  logic [INSTR_W-1:0] buf_instr;

  // While stalled in HOLD keep fetching until the skid entry is occupied.
  assign imem_req = (state == REQ) || ((state == HOLD) && !buf_valid);
`else
  assign imem_req = (state == REQ);
`endif

  // addr_q is separate from pc so a redirect can move pc while the old
  // request is still waiting for its ack.
  assign imem_addr   = addr_q;
  assign ack_hit     = imem_req && imem_ack;
  assign outstanding = imem_req && !imem_ack;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      squash     <= 1'b0;
      PCOut      <= RESET_PC;
      PCPlus4    <= RESET_PC + ADDR_W'(PC_INC);
      InstrOut   <= '0;
      InstrValid <= 1'b0;
`ifdef FETCH_BUFFER_EN
      buf_valid   <= 1'b0;
      buf_pc      <= '0;
      buf_pc_plus <= '0;
      buf_instr   <= '0;
`endif
    end else if (Branch) begin
      // Redirect wins over Stall and ack. An unanswered request must still
      // complete at its original address; its data is dropped via squash.
      pc         <= BranchTarget;
      InstrValid <= 1'b0;
      state      <= REQ;
      if (outstanding) begin
        squash <= 1'b1;
      end else begin
        squash <= 1'b0;
        addr_q <= BranchTarget;
      end
`ifdef FETCH_BUFFER_EN
      buf_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (ack_hit) begin
            if (squash) begin
              // Stale response for a pre-branch address; now fetch the target.
              squash <= 1'b0;
              addr_q <= pc;
            end else begin
              PCOut      <= pc;
              PCPlus4    <= pc_inc;
              InstrOut   <= imem_rdata;
              InstrValid <= 1'b1;
              pc         <= pc_inc;
              addr_q     <= pc_inc;
              if (Stall) begin
                state <= HOLD;
              end
            end
          end else begin
            InstrValid <= 1'b0;
          end
        end
        HOLD: begin
`ifdef FETCH_BUFFER_EN
          if (!Stall) begin
            state <= REQ;
            if (buf_valid) begin
              PCOut      <= buf_pc;
              PCPlus4    <= buf_pc_plus;
              InstrOut   <= buf_instr;
              InstrValid <= 1'b1;
              buf_valid  <= 1'b0;
            end else if (ack_hit) begin
              PCOut      <= pc;
              PCPlus4    <= pc_inc;
              InstrOut   <= imem_rdata;
              InstrValid <= 1'b1;
              pc         <= pc_inc;
              addr_q     <= pc_inc;
            end else begin
              InstrValid <= 1'b0;
            end
          end else if (ack_hit) begin
            buf_pc      <= pc;
            buf_pc_plus <= pc_inc;
            buf_instr   <= imem_rdata;
            buf_valid   <= 1'b1;
            pc          <= pc_inc;
            addr_q      <= pc_inc;
          end
`else
          if (!Stall) begin
            InstrValid <= 1'b0;
            state      <= REQ;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
